// File: rtl/div_seq_unit.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH+2 cycles per operation.
// Define DIV_SEQ_SIGNED_EN for two's-complement operands (truncating quotient, remainder takes dividend sign).
module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] resultDiv,
    output logic [WIDTH-1:0] resultMod,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH);

    // Handshake: start is a request sampled only in IDLE; done is a single-cycle
    // completion strobe, and results/div_zero stay valid until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH+1:0] shifted, trial;
    logic             borrow, last;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx, a_mag, b_mag, q_fix, r_fix;

    // quo starts as the dividend and is shifted out MSB first while quotient bits shift in
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs};
    assign borrow  = trial[WIDTH+1];
    assign rem_nx  = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    assign quo_nx  = {quo[WIDTH-2:0], ~borrow};
    assign last    = (cnt == CW'(WIDTH - 1));

`ifdef DIV_SEQ_SIGNED_EN
    logic neg_q, neg_r;
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;
    assign q_fix = neg_q ? -quo_nx : quo_nx;
    assign r_fix = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
`else
    assign a_mag = A;
    assign b_mag = B;
    assign q_fix = quo_nx;
    assign r_fix = rem_nx[WIDTH-1:0];
`endif

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (B == '0) ? DONE : RUN;
            RUN:  if (last)  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            div_zero  <= 1'b0;
            resultDiv <= '0;
            resultMod <= '0;
`ifdef DIV_SEQ_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt      <= '0;
                    div_zero <= (B == '0);
                    if (B == '0) begin
                        resultDiv <= '1;
                        resultMod <= A;
                    end else begin
                        rem <= '0;
                        quo <= a_mag;
                        dvs <= b_mag;
`ifdef DIV_SEQ_SIGNED_EN
                        neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r <= A[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    // results (with sign fix-up) land only on the edge entering DONE
                    if (last) begin
                        resultDiv <= q_fix;
                        resultMod <= r_fix;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
